// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller:
// ALU control codes, opcode/funct values, ALU op selects and FSM states.
package multicycle_controller_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_OFF = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        AOP_ADD   = 2'b00,
        AOP_SUB   = 2'b01,
        AOP_FUNCT = 2'b10,
        AOP_SLT   = 2'b11
    } alu_op_t;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC_R    = 4'd7,
        S_RTYPE_WB  = 4'd8,
        S_EXEC_I    = 4'd9,
        S_I_WB      = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12
    } state_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational alu_op + funct -> alu_ctrl mapping; also flags
// whether funct is a supported R-type operation.
module alu_op_decoder
    import multicycle_controller_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       funct_ok
);

    logic [2:0] fn_ctrl;

    // Single source of the funct mapping, then select by alu_op
    always_comb begin
        fn_ctrl  = ALU_OFF;
        funct_ok = 1'b1;
        case (funct)
            FN_ADD:  fn_ctrl = ALU_ADD;
            FN_SUB:  fn_ctrl = ALU_SUB;
            FN_AND:  fn_ctrl = ALU_AND;
            FN_OR:   fn_ctrl = ALU_OR;
            FN_SLT:  fn_ctrl = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
        unique case (alu_op)
            AOP_ADD:   alu_ctrl = ALU_ADD;
            AOP_SUB:   alu_ctrl = ALU_SUB;
            AOP_FUNCT: alu_ctrl = fn_ctrl;
            AOP_SLT:   alu_ctrl = ALU_SLT;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS-subset control FSM (Moore; pc_en also gated by zero).
// One instruction at a time, 3-5 cycles each.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alu_ctrl,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t     state, next_state;
    alu_op_t    alu_op;
    logic       alu_on;
    logic [2:0] dec_ctrl;
    logic       funct_ok;
    logic       pc_write, pc_write_cond;

    alu_op_decoder u_alu_op_decoder (
        .alu_op   (alu_op),
        .funct    (funct),
        .alu_ctrl (dec_ctrl),
        .funct_ok (funct_ok)
    );

    assign alu_ctrl = alu_on ? dec_ctrl : ALU_OFF;
    assign pc_en    = pc_write | (pc_write_cond & zero);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state and output decode
    always_comb begin
        next_state    = state;
        alu_on        = 1'b0;
        alu_op        = AOP_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        pc_src        = 2'd0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        case (state)
            S_IDLE: next_state = S_FETCH;
            S_FETCH: begin
                mem_read   = 1'b1;
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = 2'd1;
                alu_on     = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                alu_on    = 1'b1;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct_ok) begin
                            next_state = S_EXEC_R;
                        end else begin
                            illegal_op = 1'b1;
                            next_state = S_FETCH;
                        end
                    end
                    OP_LW, OP_SW:     next_state = S_MEM_ADDR;
                    OP_BEQ:           next_state = S_BRANCH;
                    OP_J:             next_state = S_JUMP;
                    OP_ADDI, OP_SLTI: next_state = S_EXEC_I;
                    default: begin
                        illegal_op = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_op     = AOP_FUNCT;
                alu_on     = 1'b1;
                next_state = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                alu_on     = 1'b1;
                next_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read   = 1'b1;
                i_or_d     = 1'b1;
                next_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                alu_op     = (opcode == OP_SLTI) ? AOP_SLT : AOP_ADD;
                alu_on     = 1'b1;
                next_state = S_I_WB;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = AOP_SUB;
                alu_on        = 1'b1;
                pc_write_cond = 1'b1;
                pc_src        = 2'd1;
                instr_done    = 1'b1;
                next_state    = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'd2;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: per-instruction cycle
// model of every output, compared once per cycle away from the edge.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    typedef struct packed {
        logic [2:0] alu_ctrl;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       instr_done;
        logic       illegal_op;
    } out_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero;
    logic [2:0] alu_ctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, instr_done, illegal_op;

    int checks = 0;
    int errors = 0;

    out_t act;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .alu_ctrl   (alu_ctrl),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .pc_en      (pc_en),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    always_comb act = {alu_ctrl, alu_src_a, alu_src_b, pc_src, pc_en,
                       i_or_d, mem_read, mem_write, ir_write, reg_dst,
                       mem_to_reg, reg_write, instr_done, illegal_op};

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %05h want %05h", tag, obs, exp);
        end
    endtask

    function automatic bit r_legal(input logic [5:0] fn);
        return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    endfunction

    function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == OP_RTYPE) return r_legal(fn);
        return op inside {OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_SLTI};
    endfunction

    function automatic int latency(input logic [5:0] op, input logic [5:0] fn);
        if (!legal(op, fn)) return 2;
        if (op == OP_LW) return 5;
        if (op == OP_BEQ || op == OP_J) return 3;
        return 4;
    endfunction

    function automatic logic [2:0] r_code(input logic [5:0] fn);
        case (fn)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            default: return ALU_SLT;
        endcase
    endfunction

    function automatic out_t idle_out();
        out_t e;
        e = '0;
        e.alu_ctrl = ALU_OFF;
        return e;
    endfunction

    // Expected outputs in cycle k (0 = fetch) of instruction op/fn
    function automatic out_t model(input logic [5:0] op, input logic [5:0] fn,
                                   input int k, input logic z);
        out_t e;
        e = idle_out();
        if (k == 0) begin
            e.mem_read = 1; e.ir_write = 1; e.pc_en = 1;
            e.alu_src_b = 1; e.alu_ctrl = ALU_ADD;
        end else if (k == 1) begin
            e.alu_src_b = 3; e.alu_ctrl = ALU_ADD;
            e.illegal_op = !legal(op, fn);
        end else if (op == OP_RTYPE) begin
            if (k == 2) begin
                e.alu_src_a = 1; e.alu_ctrl = r_code(fn);
            end else begin
                e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1;
            end
        end else if (op == OP_LW || op == OP_SW) begin
            if (k == 2) begin
                e.alu_src_a = 1; e.alu_src_b = 2; e.alu_ctrl = ALU_ADD;
            end else if (op == OP_SW) begin
                e.mem_write = 1; e.i_or_d = 1; e.instr_done = 1;
            end else if (k == 3) begin
                e.mem_read = 1; e.i_or_d = 1;
            end else begin
                e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1;
            end
        end else if (op == OP_BEQ) begin
            e.alu_src_a = 1; e.alu_ctrl = ALU_SUB; e.pc_src = 1;
            e.pc_en = z; e.instr_done = 1;
        end else if (op == OP_J) begin
            e.pc_en = 1; e.pc_src = 2; e.instr_done = 1;
        end else begin
            if (k == 2) begin
                e.alu_src_a = 1; e.alu_src_b = 2;
                e.alu_ctrl = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end else begin
                e.reg_write = 1; e.instr_done = 1;
            end
        end
        return e;
    endfunction

    // Run the first n cycles of an instruction; zm 1/2 force zero 1/0
    task automatic run_cycles(input logic [5:0] op, input logic [5:0] fn,
                              input int zm, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) begin
                opcode = op;
                funct  = fn;
            end
            zero = (zm == 1) ? 1'b1 : (zm == 2) ? 1'b0 : 1'($urandom);
            #1;
            check($sformatf("op%02h fn%02h c%0d", op, fn, k),
                  32'(act), 32'(model(op, fn, k, zero)));
            @(posedge clk);
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int zm);
        run_cycles(op, fn, zm, latency(op, fn));
    endtask

    task automatic run_random();
        logic [5:0] ops [7];
        logic [5:0] fns [5];
        int sel;
        ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_SLTI};
        fns = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
        sel = $urandom_range(0, 9);
        if (sel < 7)
            run_instr(ops[sel], fns[$urandom_range(0, 4)], 0);
        else if (sel == 7)
            run_instr(OP_RTYPE, 6'($urandom), 0);
        else
            run_instr(6'($urandom), 6'($urandom), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n  = 1'b0;
        opcode = '0;
        funct  = '0;
        zero   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 check("reset", 32'(act), 32'(idle_out()));
        rst_n = 1'b1;
        @(posedge clk);

        run_instr(OP_LW, 6'd0, 0);
        run_instr(OP_BEQ, 6'd0, 1);
        run_instr(OP_BEQ, 6'd0, 2);
        run_instr(OP_RTYPE, FN_SUB, 0);
        run_instr(OP_RTYPE, FN_SLT, 0);
        run_instr(6'b111111, 6'd0, 0);
        run_instr(OP_RTYPE, 6'd0, 0);
        run_instr(OP_SW, 6'd0, 0);
        run_instr(OP_J, 6'd0, 0);
        run_instr(OP_ADDI, 6'd0, 0);
        run_instr(OP_SLTI, 6'd0, 0);
        for (int i = 0; i < 200; i++) run_random();

        run_cycles(OP_LW, 6'd0, 0, 3);
        @(negedge clk);
        #1 check("lw memread", 32'(act), 32'(model(OP_LW, 6'd0, 3, zero)));
        rst_n = 1'b0;
        #1 check("async rst", 32'(act), 32'(idle_out()));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check($sformatf("held rst %0d", i), 32'(act), 32'(idle_out()));
        end
        rst_n = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 20; i++) run_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
